// File: rtl/dfr_pipe.sv
// dfr_pipe: WIDTH-bit, DEPTH-stage valid/ready register pipeline with bubble
// collapse, FLUSH and OCC. Build macro: DFR_PIPE_DATA_RESET_EN (data reset).
// Ports: CLK, RESET (sync, high), FLUSH; D/D_VALID/D_READY input side;
// Q/Q_VALID/Q_READY output side; OCC = number of valid stages.
module dfr_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic [WIDTH-1:0]           D,
  input  logic                       D_VALID,
  output logic                       D_READY,
  output logic [WIDTH-1:0]           Q,
  output logic                       Q_VALID,
  input  logic                       Q_READY,
  output logic [$clog2(DEPTH+1)-1:0] OCC
);

  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [OW-1:0]    occ;
  logic             tail_full;
  logic             acc;
  logic             outp;

  // A stage may advance when the consumer takes Q or
  // some stage at or beyond it is empty.
  always_comb begin
    tail_full = 1'b1;
    adv       = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      tail_full = tail_full & v[i];
      adv[i]    = Q_READY | ~tail_full;
    end
  end

  assign D_READY = adv[0];
  assign Q       = d[DEPTH-1];
  assign Q_VALID = v[DEPTH-1];
  assign OCC     = occ;
  assign acc     = D_VALID & D_READY;
  assign outp    = Q_VALID & Q_READY;

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      v   <= '0;
      occ <= '0;
    end else begin
      if (adv[0]) v[0] <= D_VALID;
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i]) v[i] <= v[i-1];
      end
      unique case ({acc, outp})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Data only moves with a valid item to cut toggling.
  always_ff @(posedge CLK) begin
`ifdef DFR_PIPE_DATA_RESET_EN
    if (RESET || FLUSH) begin
      for (int i = 0; i < int'(DEPTH); i++) d[i] <= RESET_VAL;
    end else
`endif
    begin
      if (adv[0] && D_VALID) d[0] <= D;
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i] && v[i-1]) d[i] <= d[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dfr_pipe.sv
// tb_dfr_pipe: scoreboard bench for dfr_pipe at DEPTH 3, 1, 2 and 5.
// Directed checks run on the DEPTH=3 instance; all share stimulus.
module tb_dfr_pipe;

  logic       CLK;
  logic       rs;
  logic       fl;
  logic [7:0] d;
  logic       dv;
  logic       qr [4];
  logic [7:0] q [4];
  logic       qv [4];
  logic       dr [4];
  logic [2:0] occ [4];
  logic [1:0] o3;
  logic [0:0] o1;
  logic [1:0] o2;
  logic [2:0] o5;

  typedef logic [7:0] q8_t [$];
  q8_t sb [4];

  int n_cmp;
  int n_bad;

  assign occ[0] = 3'(o3);
  assign occ[1] = 3'(o1);
  assign occ[2] = 3'(o2);
  assign occ[3] = o5;

  dfr_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h3C)) u_d3 (
    .CLK(CLK), .RESET(rs), .FLUSH(fl), .D(d), .D_VALID(dv),
    .D_READY(dr[0]), .Q(q[0]), .Q_VALID(qv[0]), .Q_READY(qr[0]),
    .OCC(o3)
  );
  dfr_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) u_d1 (
    .CLK(CLK), .RESET(rs), .FLUSH(fl), .D(d), .D_VALID(dv),
    .D_READY(dr[1]), .Q(q[1]), .Q_VALID(qv[1]), .Q_READY(qr[1]),
    .OCC(o1)
  );
  dfr_pipe #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'h3C)) u_d2 (
    .CLK(CLK), .RESET(rs), .FLUSH(fl), .D(d), .D_VALID(dv),
    .D_READY(dr[2]), .Q(q[2]), .Q_VALID(qv[2]), .Q_READY(qr[2]),
    .OCC(o2)
  );
  dfr_pipe #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h3C)) u_d5 (
    .CLK(CLK), .RESET(rs), .FLUSH(fl), .D(d), .D_VALID(dv),
    .D_READY(dr[3]), .Q(q[3]), .Q_VALID(qv[3]), .Q_READY(qr[3]),
    .OCC(o5)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  // One clock: drive inputs, score transfers, cross the edge,
  // then check OCC against the scoreboard depth.
  task automatic cyc(input logic v_in, input logic [7:0] d_in,
                     input logic [3:0] qr_in, input logic fl_in,
                     input logic rs_in);
    dv = v_in;
    d  = d_in;
    fl = fl_in;
    rs = rs_in;
    for (int k = 0; k < 4; k++) qr[k] = qr_in[k];
    #1;
    if (!rs_in && !fl_in) begin
      for (int k = 0; k < 4; k++) begin
        if (qv[k] === 1'b1 && qr[k]) begin
          if (sb[k].size() == 0) chk($sformatf("spurious_q%0d", k),
                                     32'(qv[k]), 32'(0));
          else chk($sformatf("q_data%0d", k), 32'(q[k]),
                   32'(sb[k].pop_front()));
        end
        if (dv && dr[k] === 1'b1) sb[k].push_back(d);
      end
    end
    @(posedge CLK);
    if (rs_in || fl_in) begin
      for (int k = 0; k < 4; k++) sb[k].delete();
    end
    @(negedge CLK);
    for (int k = 0; k < 4; k++)
      chk($sformatf("occ%0d", k), 32'(occ[k]), 32'(sb[k].size()));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 4'hF, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rs = 1'b1;
    fl = 1'b0;
    dv = 1'b0;
    d  = '0;
    for (int k = 0; k < 4; k++) qr[k] = 1'b1;
    @(negedge CLK);
    cyc(1'b0, 8'h00, 4'hF, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 4'hF, 1'b0, 1'b1);
    chk("rst_qv", 32'(qv[0]), 32'(0));
    chk("rst_occ", 32'(occ[0]), 32'(0));
    chk("rst_rdy", 32'(dr[0]), 32'(1));
`ifdef DFR_PIPE_DATA_RESET_EN
    chk("rst_q", 32'(q[0]), 32'h3C);
`endif

    // latency
    cyc(1'b1, 8'h5A, 4'hF, 1'b0, 1'b0);
    chk("lat_occ_k", 32'(occ[0]), 32'(1));
    chk("lat_qv_k", 32'(qv[0]), 32'(0));
    cyc(1'b0, 8'h00, 4'hF, 1'b0, 1'b0);
    chk("lat_occ_k1", 32'(occ[0]), 32'(1));
    chk("lat_qv_k1", 32'(qv[0]), 32'(0));
    cyc(1'b0, 8'h00, 4'hF, 1'b0, 1'b0);
    chk("lat_occ_k2", 32'(occ[0]), 32'(1));
    chk("lat_qv_k2", 32'(qv[0]), 32'(1));
    chk("lat_q_k2", 32'(q[0]), 32'h5A);
    cyc(1'b0, 8'h00, 4'hF, 1'b0, 1'b0);
    chk("lat_occ_k3", 32'(occ[0]), 32'(0));
    chk("lat_qv_k3", 32'(qv[0]), 32'(0));
    drain(6);

    // streaming
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 4'hF, 1'b0, 1'b0);
      chk("str_rdy", 32'(dr[0]), 32'(1));
      if (i >= 3) begin
        chk("str_qv", 32'(qv[0]), 32'(1));
        chk("str_q", 32'(q[0]), 32'(i - 2));
        chk("str_occ", 32'(occ[0]), 32'(3));
      end
    end
    drain(8);

    // back-pressure
    cyc(1'b1, 8'hA1, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA3, 4'h0, 1'b0, 1'b0);
    chk("bp_occ", 32'(occ[0]), 32'(3));
    chk("bp_rdy", 32'(dr[0]), 32'(0));
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 8'hA4, 4'h0, 1'b0, 1'b0);
      chk("bp_hold_q", 32'(q[0]), 32'hA1);
      chk("bp_hold_qv", 32'(qv[0]), 32'(1));
      chk("bp_hold_rdy", 32'(dr[0]), 32'(0));
    end
    cyc(1'b1, 8'hA4, 4'hF, 1'b0, 1'b0);
    chk("bp_full_occ", 32'(occ[0]), 32'(3));
    drain(8);

    // bubble collapse
    cyc(1'b1, 8'h11, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    chk("bub_occ", 32'(occ[0]), 32'(2));
    chk("bub_rdy", 32'(dr[0]), 32'(1));
    chk("bub_q0", 32'(q[0]), 32'h11);
    cyc(1'b0, 8'h00, 4'hF, 1'b0, 1'b0);
    chk("bub_qv1", 32'(qv[0]), 32'(1));
    chk("bub_q1", 32'(q[0]), 32'h22);
    cyc(1'b0, 8'h00, 4'hF, 1'b0, 1'b0);
    chk("bub_qv2", 32'(qv[0]), 32'(0));
    drain(8);

    // flush with a pending input
    cyc(1'b1, 8'hC1, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 4'h0, 1'b0, 1'b0);
    chk("fl_full", 32'(occ[0]), 32'(3));
    cyc(1'b1, 8'hFF, 4'hF, 1'b1, 1'b0);
    chk("fl_qv", 32'(qv[0]), 32'(0));
    chk("fl_occ", 32'(occ[0]), 32'(0));
    chk("fl_rdy", 32'(dr[0]), 32'(1));
`ifdef DFR_PIPE_DATA_RESET_EN
    chk("fl_q", 32'(q[0]), 32'h3C);
`endif
    drain(8);

    // reset together with flush mid-stream
    cyc(1'b1, 8'hD1, 4'hF, 1'b0, 1'b0);
    cyc(1'b1, 8'hD2, 4'hF, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 4'hF, 1'b1, 1'b1);
    chk("rf_qv", 32'(qv[0]), 32'(0));
    chk("rf_occ", 32'(occ[0]), 32'(0));
`ifdef DFR_PIPE_DATA_RESET_EN
    chk("rf_q", 32'(q[0]), 32'h3C);
`endif
    drain(8);

    // random traffic on all depths
    for (int n = 0; n < 10000; n++) begin
      cyc(1'($urandom), 8'($urandom), 4'($urandom),
          ($urandom_range(0, 499) == 0), 1'b0);
    end
    drain(10);
    for (int k = 0; k < 4; k++)
      chk($sformatf("end_empty%0d", k), 32'(sb[k].size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
